// File: rtl/tpu_pkg.sv
// Shared fixed-point helpers: saturation limits, clipping and the shifted lane product.
// All math runs on one wide signed type so any N up to 63 bits is handled exactly.
package tpu_pkg;

    localparam int unsigned WIDE_W = 128;

    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic wide_t sat_max(input int unsigned n);
        return (wide_t'(1) <<< (n - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_min(input int unsigned n);
        return -(wide_t'(1) <<< (n - 1));
    endfunction

    function automatic logic is_sat(input wide_t x, input int unsigned n);
        return (x > sat_max(n)) || (x < sat_min(n));
    endfunction

    function automatic wide_t sat_clip(input wide_t x, input int unsigned n);
        if (x > sat_max(n)) begin
            return sat_max(n);
        end
        if (x < sat_min(n)) begin
            return sat_min(n);
        end
        return x;
    endfunction

    // Full-precision product, arithmetic shift gives floor rounding of the Q fraction
    function automatic wide_t lane_product(input wide_t a, input wide_t b, input int unsigned q);
        return (a * b) >>> q;
    endfunction

endpackage

// File: rtl/qmult_sat.sv
// One lane of the MAC: Q-format multiply with floor shift, saturated back to N bits.
module qmult_sat
    import tpu_pkg::*;
#(
    parameter int unsigned Q = 10,
    parameter int unsigned N = 32
) (
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N-1:0] prod_c_o,
    output logic                sat_c_o
);

    wide_t shifted_c;

    always_comb begin
        shifted_c = lane_product(wide_t'(a_i), wide_t'(b_i), Q);
        sat_c_o   = is_sat(shifted_c, N);
        prod_c_o  = N'(sat_clip(shifted_c, N));
    end

endmodule

// File: rtl/vec_mac.sv
// Streaming fixed-point dot-product engine: lane multiply -> tree sum -> accumulate,
// one beat per cycle, with a held output register and global stall on output backpressure.
module vec_mac
    import tpu_pkg::*;
#(
    parameter int unsigned Q     = 10,
    parameter int unsigned N     = 32,
    parameter int unsigned LANES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES-1:0][N-1:0]     a,
    input  logic [LANES-1:0][N-1:0]     b,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [N-1:0]         out_data,
    output logic                        out_ovf
);

    localparam int unsigned SUM_W = N + $clog2(LANES);
    localparam int unsigned ACC_W = N + 1;

    logic signed [N-1:0] lane_prod_c [LANES];
    logic [LANES-1:0]    lane_sat_c;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        qmult_sat #(.Q(Q), .N(N)) u_qmult (
            .a_i      (a[g]),
            .b_i      (b[g]),
            .prod_c_o (lane_prod_c[g]),
            .sat_c_o  (lane_sat_c[g])
        );
    end

    logic                s1_valid_q, s1_valid_d;
    logic                s1_last_q,  s1_last_d;
    logic                s1_ovf_q,   s1_ovf_d;
    logic signed [N-1:0] s1_prod_q [LANES];
    logic signed [N-1:0] s1_prod_d [LANES];

    logic                s2_valid_q, s2_valid_d;
    logic                s2_last_q,  s2_last_d;
    logic                s2_ovf_q,   s2_ovf_d;
    logic signed [N-1:0] s2_sum_q,   s2_sum_d;

    logic signed [N-1:0] acc_q,      acc_d;
    logic                acc_ovf_q,  acc_ovf_d;
    logic                out_valid_q, out_valid_d;
    logic signed [N-1:0] out_data_q, out_data_d;
    logic                out_ovf_q,  out_ovf_d;

    logic                    advance_c;
    logic signed [SUM_W-1:0] tree_sum_c;
    logic                    tree_sat_c;
    logic signed [ACC_W-1:0] acc_sum_c;
    logic                    acc_sat_c;
    logic signed [N-1:0]     acc_new_c;
    logic                    vec_ovf_c;

    // A held result that is not being taken freezes every stage, including the input
    assign advance_c = !(out_valid_q && !out_ready);
    assign in_ready  = advance_c;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_ovf_d    = s1_ovf_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_ovf_d    = s2_ovf_q;
        s2_sum_d    = s2_sum_q;
        acc_d       = acc_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        tree_sum_c = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum_c = tree_sum_c + SUM_W'(s1_prod_q[i]);
        end
        tree_sat_c = is_sat(wide_t'(tree_sum_c), N);

        acc_sum_c = ACC_W'(acc_q) + ACC_W'(s2_sum_q);
        acc_sat_c = is_sat(wide_t'(acc_sum_c), N);
        acc_new_c = N'(sat_clip(wide_t'(acc_sum_c), N));
        vec_ovf_c = acc_ovf_q | s2_ovf_q | acc_sat_c;

        if (advance_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_last_d = in_last;
                s1_prod_d = lane_prod_c;
                s1_ovf_d  = |lane_sat_c;
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_last_d = s1_last_q;
                s2_sum_d  = N'(sat_clip(wide_t'(tree_sum_c), N));
                s2_ovf_d  = s1_ovf_q | tree_sat_c;
            end

            // Bubbles leave the accumulator alone; a last beat publishes and restarts it
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_new_c;
                    out_ovf_d   = vec_ovf_c;
                    acc_d       = '0;
                    acc_ovf_d   = 1'b0;
                end else begin
                    acc_d     = acc_new_c;
                    acc_ovf_d = vec_ovf_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_ovf_q    <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_prod_q[i] <= '0;
            end
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_ovf_q    <= 1'b0;
            s2_sum_q    <= '0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_ovf_q    <= s1_ovf_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_sum_q    <= s2_sum_d;
            acc_q       <= acc_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_vec_mac.sv
// Self-checking bench for vec_mac: directed scenarios plus randomized vectors
// scored against an arithmetic dot-product model.
module tb_vec_mac;

    localparam int unsigned Q     = 10;
    localparam int unsigned N     = 32;
    localparam int unsigned LANES = 4;

    typedef logic [LANES-1:0][N-1:0] lanes_t;
    typedef struct { lanes_t a; lanes_t b; bit last; } beat_t;
    typedef struct { longint data; bit ovf; int cyc; } res_t;

    localparam longint HI = (longint'(1) <<< (N - 1)) - 1;
    localparam longint LO = -(longint'(1) <<< (N - 1));

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    lanes_t             a;
    lanes_t             b;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic signed [N-1:0] out_data;
    logic               out_ovf;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     accept_cyc = 0;
    beat_t  stim_q[$];
    res_t   exp_q[$];
    res_t   got_q[$];
    longint m_acc = 0;
    bit     m_ovf = 1'b0;

    vec_mac #(.Q(Q), .N(N), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic bit oor(input longint x);
        return (x > HI) || (x < LO);
    endfunction

    function automatic longint clamp(input longint x);
        return (x > HI) ? HI : ((x < LO) ? LO : x);
    endfunction

    // Reference: exact integer products, floor division by 2^Q, clamp at each stage
    task automatic model_beat(input beat_t bt);
        longint p, s, t;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            p = (longint'($signed(bt.a[i])) * longint'($signed(bt.b[i]))) >>> Q;
            if (oor(p)) m_ovf = 1'b1;
            s = s + clamp(p);
        end
        if (oor(s)) m_ovf = 1'b1;
        s = clamp(s);
        t = m_acc + s;
        if (oor(t)) m_ovf = 1'b1;
        m_acc = clamp(t);
        if (bt.last) begin
            exp_q.push_back('{m_acc, m_ovf, 0});
            m_acc = 0;
            m_ovf = 1'b0;
        end
    endtask

    task automatic add_beat(input beat_t bt);
        model_beat(bt);
        stim_q.push_back(bt);
    endtask

    task automatic clear_all();
        stim_q.delete();
        exp_q.delete();
        got_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
        a        = '0;
        b        = '0;
    endtask

    function automatic beat_t mk_beat(input longint a0, a1, a2, a3, b0, b1, b2, b3, input bit last);
        beat_t bt;
        bt.a[0] = N'(a0); bt.a[1] = N'(a1); bt.a[2] = N'(a2); bt.a[3] = N'(a3);
        bt.b[0] = N'(b0); bt.b[1] = N'(b1); bt.b[2] = N'(b2); bt.b[3] = N'(b3);
        bt.last = last;
        return bt;
    endfunction

    // Streams stim_q into the DUT and collects handshaken results into got_q
    task automatic run_traffic(input int gap_pct, input int ready_pct, input int budget, output bit timeout);
        int n;
        n = 0;
        timeout = 1'b0;
        while (stim_q.size() != 0 || got_q.size() < exp_q.size()) begin
            if (n >= budget) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            n++;
            if (stim_q.size() != 0 && $urandom_range(99) >= gap_pct) begin
                in_valid = 1'b1;
                a        = stim_q[0].a;
                b        = stim_q[0].b;
                in_last  = stim_q[0].last;
            end else begin
                in_valid = 1'b0;
                a        = {$urandom, $urandom, $urandom, $urandom};
                b        = {$urandom, $urandom, $urandom, $urandom};
                in_last  = 1'($urandom_range(1));
            end
            out_ready = ($urandom_range(99) < ready_pct);
            #1;
            if (in_valid && in_ready) begin
                accept_cyc = cyc;
                void'(stim_q.pop_front());
            end
            if (out_valid && out_ready) got_q.push_back('{longint'(out_data), out_ovf, cyc});
        end
        @(negedge clk);
        cyc++;
        idle_inputs();
        out_ready = 1'b0;
    endtask

    function automatic logic [N-1:0] rand_val();
        case ($urandom_range(3))
            0: return N'($urandom);
            1: return N'(int'($urandom_range(8192)) - 4096);
            2: return N'(int'($urandom_range(1 << 21)) - (1 << 20));
            default: begin
                case ($urandom_range(4))
                    0: return 32'h7FFF_FFFF;
                    1: return 32'h8000_0000;
                    2: return 32'hFFFF_FFFF;
                    3: return 32'h0000_0001;
                    default: return 32'h0000_0000;
                endcase
            end
        endcase
    endfunction

    task automatic test_reset();
        clear_all();
        idle_inputs();
        out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_single();
        bit to;
        clear_all();
        add_beat(mk_beat(1024, 2048, -1024, 512, 1024, 1024, 1024, 2048, 1'b1));
        run_traffic(0, 100, 20, to);
        checks++; if (to || got_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d results expected 1 (timeout %0b)", got_q.size(), to); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0].data !== 64'sd3072) begin errors++; $display("FAIL single_data: got %0d expected 3072", got_q[0].data); end
            checks++; if (got_q[0].ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b expected 0", got_q[0].ovf); end
            checks++; if (got_q[0].cyc - accept_cyc !== 3) begin errors++; $display("FAIL single_latency: got %0d expected 3", got_q[0].cyc - accept_cyc); end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        clear_all();
        for (int i = 0; i < 3; i++) add_beat(mk_beat(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, i == 2));
        add_beat(mk_beat(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1'b1));
        run_traffic(0, 100, 30, to);
        checks++; if (to || got_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d results expected 2 (timeout %0b)", got_q.size(), to); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0].data !== 64'sd12288) begin errors++; $display("FAIL b2b_first: got %0d expected 12288", got_q[0].data); end
            checks++; if (got_q[1].data !== 64'sd4096) begin errors++; $display("FAIL b2b_second: got %0d expected 4096", got_q[1].data); end
            checks++; if (got_q[1].cyc - got_q[0].cyc !== 1) begin errors++; $display("FAIL b2b_gap: got %0d cycles apart expected 1", got_q[1].cyc - got_q[0].cyc); end
        end
    endtask

    task automatic test_saturation();
        bit to;
        clear_all();
        add_beat(mk_beat(32'h7FFF_FFFF, 0, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 1'b1));
        add_beat(mk_beat(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1'b1));
        run_traffic(0, 100, 30, to);
        checks++; if (to || got_q.size() != 2) begin errors++; $display("FAIL sat_count: got %0d results expected 2 (timeout %0b)", got_q.size(), to); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0].data !== 64'sh7FFF_FFFF) begin errors++; $display("FAIL sat_data: got %0h expected 7fffffff", got_q[0].data); end
            checks++; if (got_q[0].ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", got_q[0].ovf); end
            checks++; if (got_q[1].data !== 64'sd4096) begin errors++; $display("FAIL sat_next_data: got %0d expected 4096", got_q[1].data); end
            checks++; if (got_q[1].ovf !== 1'b0) begin errors++; $display("FAIL sat_next_ovf: got %b expected 0", got_q[1].ovf); end
        end
    endtask

    task automatic test_stall();
        bit    to;
        int    n;
        beat_t ba, bb;
        clear_all();
        ba = mk_beat(2048, 0, 0, 0, 1024, 0, 0, 0, 1'b1);
        bb = mk_beat(1024, 1024, 1024, 0, 3072, 3072, 3072, 0, 1'b1);
        model_beat(ba);
        model_beat(bb);
        @(negedge clk); cyc++;
        out_ready = 1'b0;
        in_valid = 1'b1; a = ba.a; b = ba.b; in_last = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_a: in_ready got %b expected 1", in_ready); end
        @(negedge clk); cyc++;
        a = bb.a; b = bb.b; in_last = 1'b1;
        @(negedge clk); cyc++;
        idle_inputs();
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_wait: out_valid got %b expected 1", out_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", i, in_ready); end
            checks++; if (longint'(out_data) !== exp_q[0].data) begin errors++; $display("FAIL stall_hold: cycle %0d got %0d expected %0d", i, out_data, exp_q[0].data); end
            @(negedge clk);
        end
        run_traffic(0, 100, 20, to);
        checks++; if (to || got_q.size() != 2) begin errors++; $display("FAIL stall_count: got %0d results expected 2 (timeout %0b)", got_q.size(), to); end
        if (got_q.size() >= 2) begin
            checks++; if (got_q[0].data !== 64'sd2048) begin errors++; $display("FAIL stall_first: got %0d expected 2048", got_q[0].data); end
            checks++; if (got_q[1].data !== 64'sd9216) begin errors++; $display("FAIL stall_second: got %0d expected 9216", got_q[1].data); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_all();
        add_beat(mk_beat(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1'b0));
        add_beat(mk_beat(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 1'b0));
        run_traffic(0, 100, 10, to);
        rst = 1'b1;
        @(negedge clk); cyc++;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        clear_all();
        add_beat(mk_beat(1024, 0, 0, 0, 1024, 0, 0, 0, 1'b1));
        run_traffic(0, 100, 20, to);
        checks++; if (to || got_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d results expected 1 (timeout %0b)", got_q.size(), to); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0].data !== 64'sd1024) begin errors++; $display("FAIL rstmid_data: got %0d expected 1024", got_q[0].data); end
        end
    endtask

    task automatic test_floor();
        bit to;
        clear_all();
        add_beat(mk_beat(-1, 0, 0, 0, 1, 0, 0, 0, 1'b1));
        run_traffic(0, 100, 20, to);
        checks++; if (to || got_q.size() != 1) begin errors++; $display("FAIL floor_count: got %0d results expected 1 (timeout %0b)", got_q.size(), to); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0].data !== -64'sd1) begin errors++; $display("FAIL floor_data: got %0d expected -1", got_q[0].data); end
        end
    endtask

    task automatic test_random();
        bit    to;
        int    len;
        beat_t bt;
        clear_all();
        for (int v = 0; v < 120; v++) begin
            len = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                for (int i = 0; i < LANES; i++) begin
                    bt.a[i] = rand_val();
                    bt.b[i] = rand_val();
                end
                bt.last = (k == len - 1);
                add_beat(bt);
            end
        end
        run_traffic(20, 70, 5000, to);
        checks++; if (to || got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d results expected %0d (timeout %0b)", got_q.size(), exp_q.size(), to); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++; if (got_q[i].data !== exp_q[i].data) begin errors++; $display("FAIL rand_data[%0d]: got %0d expected %0d", i, got_q[i].data, exp_q[i].data); end
            checks++; if (got_q[i].ovf !== exp_q[i].ovf) begin errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", i, got_q[i].ovf, exp_q[i].ovf); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_saturation();
        test_stall();
        test_reset_mid();
        test_floor();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vec_mac.md
VEC_MAC -- requirements
Module: vec_mac

Interface
REQ-001 The block SHALL have parameter Q, default 10, meaning number of fractional bits of the signed fixed-point format.
REQ-002 The block SHALL have parameter N, default 32, meaning total signed word width.
REQ-003 The block SHALL have parameter LANES, default 4, meaning number of parallel products per input beat (power of two, >=1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: beat present on a/b/in_last.
REQ-007 The block SHALL have port in_ready, output, 1 bit: beat accepted when in_valid && in_ready at the clock edge.
REQ-008 The block SHALL have port a, input, LANES x N bits signed: multiplicand per lane.
REQ-009 The block SHALL have port b, input, LANES x N bits signed: multiplier per lane.
REQ-010 The block SHALL have port in_last, input, 1 bit: beat is the final beat of a vector.
REQ-011 The block SHALL have port out_valid, output, 1 bit: a vector result is held on out_data/out_ovf.
REQ-012 The block SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-013 The block SHALL have port out_data, output, N bits signed: saturated dot-product result.
REQ-014 The block SHALL have port out_ovf, output, 1 bit: sticky flag, set if any saturation occurred anywhere in that vector.

Function
REQ-015 Per lane, the block SHALL form the full 2N-bit product, arithmetic-right-shift it by Q (floor), and saturate it to [-2^(N-1), 2^(N-1)-1].
REQ-016 The block SHALL sum the LANES lane results at width N+log2(LANES), then saturate the sum to N bits.
REQ-017 The block SHALL add the beat sum to the accumulator at N+1 bits, then saturate the result to N bits.
REQ-018 The block SHALL have a 3-stage pipeline: S1 registers the lane products, S2 registers the tree sum, S3 updates the accumulator.
REQ-019 The block SHALL drive out_valid high on the third cycle after acceptance of a beat with in_last=1, with out_data set to accumulator plus that beat's sum (saturated).
REQ-020 On that same edge, the block SHALL clear the accumulator and sticky overflow to 0, so the next beat starts a fresh vector with no idle cycle.
REQ-021 Stall: advance = !(out_valid && !out_ready); in_ready SHALL equal advance, and all stage registers SHALL hold while advance=0.
REQ-022 out_data and out_ovf SHALL remain stable while out_valid && !out_ready.
REQ-023 If out_valid && out_ready and a new last beat reaches S3 on the same edge, the block SHALL load the new result with out_valid staying high.
REQ-024 Pipeline bubbles (no beat accepted) SHALL propagate as invalid stages and SHALL leave the accumulator unchanged.
REQ-025 The sum from S3 SHALL be bit-exact to the product/sum/accumulate rules above for every LANES, Q and N.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL clear all stage valid bits, the accumulator and the sticky flag, and set out_valid=0, out_data=0 and out_ovf=0.
REQ-027 Reset mid-vector SHALL discard all partial vectors and in-flight beats; in_ready SHALL be 1 in the first cycle after reset.

Structure
REQ-028 Package tpu_pkg SHALL hold the fixed-point saturation limit functions/constants and a parametrised lane-product helper.
REQ-029 Sub-module qmult_sat SHALL implement REQ-015 (one instance per lane) and report a per-lane saturation bit.
REQ-030 The remaining RTL (adder tree, accumulator, stall control, output register) SHALL reside in vec_mac.

Verification (Q=10, N=32, LANES=4; 1.0=1024)
REQ-031 The bench SHALL cover single beat a={1024,2048,-1024,512}, b={1024,1024,1024,2048}, last=1 -> out_data=3072, out_ovf=0, out_valid exactly 3 cycles after acceptance.
REQ-032 The bench SHALL cover 3 back-to-back beats with all lanes a=b=1024 and last on beat 3, followed immediately by a 1-beat vector of the same data -> results 12288, then 4096, with no gap.
REQ-033 The bench SHALL cover lane0 a=b=0x7FFFFFFF with other lanes 0 -> out_data=0x7FFFFFFF, out_ovf=1; the next vector, with no saturation, -> out_ovf=0.
REQ-034 The bench SHALL cover out_ready=0 while a result is valid and a second vector is in flight -> in_ready=0 and out_data stable; on releasing out_ready -> both results delivered in order, unchanged.
REQ-035 The bench SHALL cover rst pulsed after 2 non-last beats, then a 1-beat vector a=b={1024,0,0,0} -> out_data=1024.
REQ-036 The bench SHALL cover raw lane a=-1, b=1, other lanes 0 -> out_data=-1 (floor shift).
